// File: rtl/voting_pkg.sv
// Shared definitions for the voting tally controller.
// Holds the FSM state encoding and the default size constants.
package voting_pkg;

    localparam int N_DEF = 2;
    localparam int M_DEF = 2;
    localparam int NCAND = 2 ** N_DEF;
    localparam int NVOTE = 2 ** M_DEF;
    localparam int TW    = M_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SCAN    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/voting_max_scan.sv
// Running-maximum unit: one candidate tally per enabled cycle.
// Ports: clk, rst, clear (zero result), en, k (candidate index),
//        tally_k (its tally), winner, win_count (running result).
module voting_max_scan #(
    parameter int N  = 2,
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [N-1:0]  k,
    input  logic [TW-1:0] tally_k,
    output logic [N-1:0]  winner,
    output logic [TW-1:0] win_count
);

    logic [N-1:0]  idx_q;
    logic [TW-1:0] max_q;

    // k==0 seeds the maximum; afterwards only a strictly larger
    // tally replaces it, so ties keep the lowest index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            max_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
            max_q <= '0;
        end else if (en) begin
            if (k == '0 || tally_k > max_q) begin
                idx_q <= k;
                max_q <= tally_k;
            end
        end
    end

    assign winner    = idx_q;
    assign win_count = max_q;

endmodule

// File: rtl/voting_tally_ctrl.sv
// Vote collector and winner scheduler with a shared max-scan unit.
// Ports: clk, rst, start, vote_valid/vote_id/vote_cand/vote_ready,
//        close, dup_err, busy, done, winner, win_count.
module voting_tally_ctrl
    import voting_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         vote_valid,
    input  logic [M-1:0] vote_id,
    input  logic [N-1:0] vote_cand,
    output logic         vote_ready,
    input  logic         close,
    output logic         dup_err,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] winner,
    output logic [M:0]   win_count
);

    localparam int NUM_CAND = 2 ** N;
    localparam int NUM_VOTE = 2 ** M;
    localparam int TALLY_W  = M + 1;

    state_t               state_q;
    logic [NUM_VOTE-1:0]  voted_q;
    logic [NUM_VOTE-1:0]  voted_d;
    logic [TALLY_W-1:0]   tally_q [NUM_CAND];
    logic [TALLY_W-1:0]   tally_inc;
    logic [N-1:0]         k_q;
    logic                 dup_err_q;
    logic                 accept;
    logic                 is_dup;
    logic                 new_vote;
    logic                 scan_clr;
    logic                 scan_en;

    assign accept    = vote_valid && state_q == ST_COLLECT;
    assign is_dup    = voted_q[vote_id];
    assign new_vote  = accept && !is_dup;
    assign tally_inc = tally_q[vote_cand] + TALLY_W'(1);
    assign scan_clr  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign scan_en   = state_q == ST_SCAN;

    always_comb begin
        voted_d = voted_q;
        if (new_vote)
            voted_d = voted_q | (NUM_VOTE'(1) << vote_id);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            voted_q   <= '0;
            k_q       <= '0;
            dup_err_q <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++)
                tally_q[i] <= '0;
        end else begin
            dup_err_q <= accept && is_dup;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_COLLECT;
                        voted_q <= '0;
                        k_q     <= '0;
                        for (int i = 0; i < NUM_CAND; i++)
                            tally_q[i] <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (new_vote) begin
                        voted_q            <= voted_d;
                        tally_q[vote_cand] <= tally_inc;
                    end
                    // A vote arriving with close is counted first.
                    if (close || &voted_d) begin
                        state_q <= ST_SCAN;
                        k_q     <= '0;
                    end
                end
                ST_SCAN: begin
                    k_q <= k_q + N'(1);
                    if (&k_q)
                        state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    voting_max_scan #(
        .N  (N),
        .TW (TALLY_W)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .clear     (scan_clr),
        .en        (scan_en),
        .k         (k_q),
        .tally_k   (tally_q[k_q]),
        .winner    (winner),
        .win_count (win_count)
    );

    assign vote_ready = state_q == ST_COLLECT;
    assign busy       = state_q == ST_COLLECT || state_q == ST_SCAN;
    assign done       = state_q == ST_DONE;
    assign dup_err    = dup_err_q;

endmodule

// File: tb/tb_voting_tally_ctrl.sv
// Directed bench for voting_tally_ctrl (N=2, M=2).
// Hand-computed winners, latencies and handshake flags.
module tb_voting_tally_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       vote_valid = 1'b0;
    logic [1:0] vote_id = '0;
    logic [1:0] vote_cand = '0;
    logic       vote_ready;
    logic       close = 1'b0;
    logic       dup_err;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic [2:0] win_count;

    int n_checks = 0;
    int n_fail   = 0;

    voting_tally_ctrl #(.N(2), .M(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vote_valid (vote_valid),
        .vote_id    (vote_id),
        .vote_cand  (vote_cand),
        .vote_ready (vote_ready),
        .close      (close),
        .dup_err    (dup_err),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .win_count  (win_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_close();
        @(negedge clk);
        close = 1'b1;
        @(posedge clk);
        #1;
        close = 1'b0;
    endtask

    task automatic do_vote(input int id, input int cand, input bit cl);
        @(negedge clk);
        vote_valid = 1'b1;
        vote_id    = 2'(id);
        vote_cand  = 2'(cand);
        close      = cl;
        @(posedge clk);
        #1;
        vote_valid = 1'b0;
        close      = 1'b0;
    endtask

    // Latency counts the edge that took the last vote/close.
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_lat"}, 32'(cyc + 1), 32'd5);
    endtask

    task automatic check_result(input string tag, input int w, input int c);
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_win"}, 32'(winner), 32'(w));
        check_eq({tag, "_cnt"}, 32'(win_count), 32'(c));
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(vote_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dup", 32'(dup_err), 32'd0);
        check_eq("rst_win", 32'(winner), 32'd0);
        check_eq("rst_cnt", 32'(win_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: all four voters, auto scan
        do_start();
        check_eq("t1_ready", 32'(vote_ready), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        do_vote(0, 2, 1'b0);
        do_vote(1, 2, 1'b0);
        do_vote(2, 1, 1'b0);
        do_vote(3, 3, 1'b0);
        check_eq("t1_scan_ready", 32'(vote_ready), 32'd0);
        check_eq("t1_scan_busy", 32'(busy), 32'd1);
        wait_done("t1");
        check_result("t1", 2, 2);
        // close outside COLLECT ignored; DONE holds
        do_close();
        repeat (3) @(posedge clk);
        #1;
        check_result("t1_hold", 2, 2);
        check_eq("t1_hold_busy", 32'(busy), 32'd0);

        // 2: tie, lowest index wins; start mid-collect ignored
        do_start();
        check_eq("t2_clr_win", 32'(winner), 32'd0);
        check_eq("t2_clr_cnt", 32'(win_count), 32'd0);
        do_vote(0, 1, 1'b0);
        do_start();
        do_vote(1, 3, 1'b0);
        do_close();
        wait_done("t2");
        check_result("t2", 1, 1);

        // 3: duplicate voter
        do_start();
        do_vote(1, 0, 1'b0);
        check_eq("t3_dup_first", 32'(dup_err), 32'd0);
        do_vote(1, 3, 1'b0);
        check_eq("t3_dup_pulse", 32'(dup_err), 32'd1);
        do_close();
        check_eq("t3_dup_clear", 32'(dup_err), 32'd0);
        wait_done("t3");
        check_result("t3", 0, 1);

        // 4: no votes
        do_start();
        do_close();
        wait_done("t4");
        check_result("t4", 0, 0);

        // 5: close together with an accepted vote
        do_start();
        do_vote(2, 3, 1'b1);
        check_eq("t5_ready", 32'(vote_ready), 32'd0);
        wait_done("t5");
        check_result("t5", 3, 1);

        // 6: reset mid-scan, then a clean election
        do_start();
        do_vote(0, 1, 1'b0);
        do_close();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_done", 32'(done), 32'd0);
        check_eq("t6_rst_ready", 32'(vote_ready), 32'd0);
        check_eq("t6_rst_win", 32'(winner), 32'd0);
        check_eq("t6_rst_cnt", 32'(win_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        for (int i = 0; i < 4; i++)
            do_vote(i, 0, 1'b0);
        wait_done("t6");
        check_result("t6", 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
